key_mode_ctrl: RTL

Front-end conditioner for the light-pattern sequencer. Takes two raw, bouncy, asynchronous push-buttons and produces the sequencer's mode level `M` and its clear pulse `cr_out`. Both outputs are clean, registered and synchronous to `clk`. It sits directly upstream of the pattern-stepping stage: `M` selects the stepping sequence, and `cr_out` forces that stage to its initial pattern.

---
 rtl/key_mode_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/key_mode_ctrl.sv
// key_mode_ctrl
//   Front-end conditioner for the light-pattern sequencer. Two raw, bouncy,
//   asynchronous push-buttons are synchronized and debounced. The results
//   drive a mode level that toggles on each accepted mode press, and a clear
//   pulse of fixed width for the pattern-stepping stage.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive identical synchronized samples needed before
//                    a key state is accepted (>= 1)
//   CR_PULSE_CYCLES  width of cr_out in clk cycles (>= 1)
//
// Ports
//   clk         in   system clock, rising edge
//   CR          in   synchronous active-high reset
//   key_mode    in   raw mode button, active-high, asynchronous
//   key_clr     in   raw clear button, active-high, asynchronous
//   M           out  mode level, toggles on each accepted mode press
//   mode_pulse  out  one-cycle strobe coincident with each M toggle
//   cr_out      out  active-high clear for the downstream stage; it is also
//                    asserted by reset, which gives a power-on clear
module key_mode_ctrl #(
  parameter int DEBOUNCE_CYCLES = 10,
  parameter int CR_PULSE_CYCLES = 2
) (
  input  logic clk,
  input  logic CR,
  input  logic key_mode,
  input  logic key_clr,
  output logic M,
  output logic mode_pulse,
  output logic cr_out
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PW = (CR_PULSE_CYCLES > 1) ? $clog2(CR_PULSE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PC_LOAD  = PW'(CR_PULSE_CYCLES - 1);

  // Bit 0 carries the mode key, bit 1 carries the clear key.
  logic [1:0]         s1_q, s1_d;
  logic [1:0]         s2_q, s2_d;
  logic [1:0]         stb_q, stb_d;
  logic [1:0][CW-1:0] cnt_q, cnt_d;
  logic [1:0]         press;

  logic          m_q, m_d;
  logic          mode_pulse_q, mode_pulse_d;
  logic          cr_out_q, cr_out_d;
  logic [PW-1:0] pc_q, pc_d;

  // One debounce step for a single key. It returns {press, stb_next, cnt_next}.
  // Any sample that matches the stable state restarts the count. A change is
  // accepted only after DEBOUNCE_CYCLES differing samples in a row.
  function automatic logic [CW+1:0] deb_next(input logic          s2,
                                              input logic          stb,
                                              input logic [CW-1:0] cnt);
    logic          prs;
    logic          stb_n;
    logic [CW-1:0] cnt_n;
    prs   = 1'b0;
    stb_n = stb;
    cnt_n = cnt;
    if (s2 == stb) begin
      cnt_n = '0;
    end else if (cnt == CNT_LAST) begin
      stb_n = s2;
      cnt_n = '0;
      prs   = s2;
    end else begin
      cnt_n = cnt + CW'(1);
    end
    return {prs, stb_n, cnt_n};
  endfunction

  always_comb begin
    s1_d  = {key_clr, key_mode};
    s2_d  = s1_q;
    stb_d = stb_q;
    cnt_d = cnt_q;
    press = '0;

    {press[0], stb_d[0], cnt_d[0]} = deb_next(s2_q[0], stb_q[0], cnt_q[0]);
    {press[1], stb_d[1], cnt_d[1]} = deb_next(s2_q[1], stb_q[1], cnt_q[1]);

    // Mode action fires on the same edge the press is accepted.
    m_d          = m_q ^ press[0];
    mode_pulse_d = press[0];

    // A press reloads the pulse counter even while cr_out is already high.
    // A second press therefore extends the pulse and never shortens it.
    cr_out_d = 1'b0;
    pc_d     = pc_q;
    if (press[1]) begin
      cr_out_d = 1'b1;
      pc_d     = PC_LOAD;
    end else if (pc_q != '0) begin
      cr_out_d = 1'b1;
      pc_d     = pc_q - PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (CR) begin
      s1_q         <= '0;
      s2_q         <= '0;
      stb_q        <= '0;
      cnt_q        <= '0;
      m_q          <= 1'b0;
      mode_pulse_q <= 1'b0;
      cr_out_q     <= 1'b1;
      pc_q         <= PC_LOAD;
    end else begin
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      stb_q        <= stb_d;
      cnt_q        <= cnt_d;
      m_q          <= m_d;
      mode_pulse_q <= mode_pulse_d;
      cr_out_q     <= cr_out_d;
      pc_q         <= pc_d;
    end
  end

  assign M          = m_q;
  assign mode_pulse = mode_pulse_q;
  assign cr_out     = cr_out_q;

endmodule
